// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   parity_e    - line parity mode as carried on the 2-bit configuration input
//   tx_state_e  - transmit frame sequencer states
//   MIN_DIVISOR - smallest usable baud divisor; smaller requests are raised to it
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam int unsigned MIN_DIVISOR = 2;

  function automatic logic parity_enabled(input parity_e p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

  function automatic logic parity_inverted(input parity_e p);
    return p == PAR_ODD;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-in first-out buffer.
//   i_clk/i_rst_n  clock, synchronous active-low reset (empties the FIFO)
//   i_wr_data/i_wr_en  write port; ignored while o_full
//   i_rd_en        pop the head entry; ignored while o_empty
//   o_rd_data      head entry (valid while !o_empty)
//   o_full/o_empty/o_count  status, all from registered occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  assign o_full    = (count_q == (AW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  assign wr_fire = i_wr_en && !o_full;
  assign rd_fire = i_rd_en && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy governs what is visible.
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a transmit FIFO.
//   i_clk/i_rst_n  clock, synchronous active-low reset (aborts frame, flushes FIFO)
//   i_data/i_valid/o_ready  write port; accepted when i_valid && o_ready
//   i_divisor      clock cycles per bit (0 and 1 behave as 2)
//   i_parity       00 none, 01 even, 10 odd, 11 none
//   i_stop2        two stop bits when set
//   o_tx           registered serial line, idle high
//   o_busy         a frame is in progress
//   o_count        FIFO occupancy
// Divisor, parity and stop configuration are captured when a frame starts
// and held for that whole frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DIV_WIDTH-1:0]          i_divisor,
  input  logic [1:0]                    i_parity,
  input  logic                          i_stop2,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned BW = $clog2(DATA_BITS);

  logic                 fifo_empty, fifo_full, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rd_data;

  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  parity_e              par_mode_q, par_mode_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;

  logic                 bit_done, frame_end, load;
  logic [DIV_WIDTH-1:0] div_in_clamped;
  parity_e              cfg_par;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_data (i_data),
    .i_wr_en   (i_valid),
    .i_rd_en   (fifo_pop),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (o_count)
  );

  assign o_ready = !fifo_full;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != IDLE);

  assign div_in_clamped = (i_divisor < DIV_WIDTH'(MIN_DIVISOR)) ? DIV_WIDTH'(MIN_DIVISOR)
                                                                : i_divisor;
  assign cfg_par  = parity_e'(i_parity);
  assign bit_done = (baud_cnt_q == div_q - DIV_WIDTH'(1));

  // Next-state: each bit lasts div_q cycles; the last stop bit either
  // reloads straight into START (no idle gap) or falls back to IDLE.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    div_d      = div_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    frame_end  = 1'b0;
    load       = 1'b0;
    fifo_pop   = 1'b0;

    if (state_q == IDLE) begin
      load = !fifo_empty;
    end else if (!bit_done) begin
      baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
    end else begin
      baud_cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            state_d = parity_enabled(par_mode_q) ? PARITY : STOP1;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
        PARITY: state_d = STOP1;
        STOP1: begin
          if (stop2_q) state_d = STOP2;
          else         frame_end = 1'b1;
        end
        STOP2:   frame_end = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    if (frame_end) begin
      if (fifo_empty) state_d = IDLE;
      else            load    = 1'b1;
    end

    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      shift_d    = fifo_rd_data;
      div_d      = div_in_clamped;
      par_mode_d = cfg_par;
      stop2_d    = i_stop2;
      par_bit_d  = (^fifo_rd_data) ^ parity_inverted(cfg_par);
    end
  end

  // Line level follows the current state one cycle later through tx_q,
  // so the line never sees combinational glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      div_q      <= DIV_WIDTH'(MIN_DIVISOR);
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      div_q      <= div_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, frame data width (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of the runtime baud divisor.
REQ-004 SHALL have one clock and a synchronous active-low reset, named i_clk and i_rst_n.
REQ-005 Ports, in order: name, direction, width, meaning:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  synchronous reset, active low
- i_data  in  DATA_BITS  byte to enqueue
- i_valid  in  1  write request
- o_ready  out  1  FIFO not full; a write is accepted when i_valid && o_ready
- i_divisor  in  DIV_WIDTH  clock cycles per bit
- i_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- i_stop2  in  1  1 selects two stop bits
- o_tx  out  1  serial line, idle high
- o_busy  out  1  frame in progress
- o_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Function
REQ-006 FIFO SHALL be first-in first-out; a write to a full FIFO is not accepted and data is not lost or overwritten.
REQ-007 Simultaneous accepted write and pop SHALL leave o_count unchanged; o_ready SHALL derive from the registered count (a pop does not free a slot in the same cycle).
REQ-008 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-009 IDLE: o_tx=1, o_busy=0; when FIFO non-empty, pop the head entry, load it into the shift register, latch i_divisor/i_parity/i_stop2, go to START.
REQ-010 The configuration latched at frame start SHALL be used for the whole frame; changes mid-frame take effect on the next frame.
REQ-011 Latched divisor values 0 and 1 SHALL be treated as 2.
REQ-012 Each bit SHALL hold o_tx for exactly the latched divisor count of cycles.
REQ-013 START drives 0; DATA shifts out DATA_BITS bits LSB first; PARITY (only if mode even/odd) drives XOR of the data bits (even) or its inverse (odd); STOP1 drives 1; STOP2 (only if i_stop2 latched) drives 1.
REQ-014 Into an empty FIFO in IDLE, o_tx SHALL go low on the second rising edge after the accepting edge.
REQ-015 On the last cycle of the final stop bit, a non-empty FIFO SHALL pop and start the next START bit on the next cycle, with no idle gap; an empty FIFO returns to IDLE.
REQ-016 o_busy SHALL be 1 in every state except IDLE.
REQ-017 o_tx SHALL be registered (glitch-free).

Reset
REQ-018 While i_rst_n=0 at a rising edge: o_tx=1, o_busy=0, o_count=0, o_ready=1, state IDLE, baud counter cleared, FIFO pointers zero.
REQ-019 Reset mid-frame SHALL abort the frame and discard all FIFO contents; o_tx is high from the first reset edge.

Structure
REQ-020 Parity encodings and FSM state encodings SHALL live in a shared package uart_pkg.
REQ-021 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; same clock/reset), reusable by a future RX block.

Verification
REQ-022 8N1, div=4, write 0xA5 -> o_tx: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; o_busy high for exactly 40 cycles.
REQ-023 Parity: 0x07 with even -> parity bit 1; with odd -> parity bit 0; frame 44 cycles at div=4.
REQ-024 FIFO_DEPTH=4, div=16, i_valid on 6 consecutive cycles -> first 5 accepted (1 popped immediately), o_ready low after the 5th, 6th accepted only after the first frame's final stop bit.
REQ-025 Two bytes, i_stop2=1, div=2 -> stop interval 4 cycles, second start bit on the cycle immediately after it, no idle cycle.
REQ-026 Reset asserted in DATA with 3 entries queued -> next edge: o_tx=1, o_busy=0, o_count=0; no further frames.
REQ-027 Change i_divisor from 4 to 8 mid-frame -> current frame stays at 4 cycles/bit, next frame at 8.
